infra_reset_sequencer: RTL and testbench

Sequences bring-up of the board clock/IDELAY infrastructure on the system clock domain. Waits for the clock generator lock to be stable, pulses the IDELAY controller reset, waits for its ready flag with timeout and bounded retries, then releases the user design reset. It sits between the infrastructure block's `sys_clk_lock`/`idelay_rdy` outputs and its `idelay_rst` input, and drives the design-wide reset.

---
 rtl/infra_reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_infra_reset_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infra_reset_sequencer.sv
// infra_reset_sequencer
//
// Brings up the board clock/IDELAY infrastructure on the system clock. It waits
// for the clock generator lock to stay high long enough, holds the IDELAY
// controller in reset, then waits for its ready flag. A missing ready flag is
// retried a bounded number of times before the block gives up in FAULT. Once
// ready is seen, the design-wide reset is released.
//
// Ports:
//   sys_clk      in   system clock, the only clock of this block
//   sys_rst_n    in   asynchronous active-low reset
//   clk_lock     in   clock generator lock (asynchronous, synchronised here)
//   idelay_rdy   in   IDELAY controller ready (asynchronous, synchronised here)
//   soft_rst     in   synchronous single-cycle restart request
//   idelay_rst   out  IDELAY controller reset, active high
//   user_rst     out  design reset, active high
//   ready        out  high only in RUN
//   fault        out  high only in FAULT
//   retry_count  out  diagnostic retry counter, saturates at 3
//   state        out  encoded state: 0 WAIT_LOCK, 1 LOCK_STABLE, 2 DLY_RST,
//                     3 WAIT_RDY, 4 RUN, 5 FAULT
module infra_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned RST_HOLD_CYCLES    = 64,
    parameter int unsigned RDY_TIMEOUT        = 4096,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       clk_lock,
    input  logic       idelay_rdy,
    input  logic       soft_rst,
    output logic       idelay_rst,
    output logic       user_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StWaitLock   = 3'd0,
        StLockStable = 3'd1,
        StDlyRst     = 3'd2,
        StWaitRdy    = 3'd3,
        StRun        = 3'd4,
        StFault      = 3'd5
    } state_e;

    // Counter value on the last cycle of each timed state.
    localparam logic [15:0] LockLast    = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] HoldLast    = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(RDY_TIMEOUT - 1);
    localparam logic [1:0]  MaxRetries  = 2'(MAX_RETRIES);

    logic        lock_meta_q, lock_s;
    logic        rdy_meta_q, rdy_s;
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  retry_q, retry_d;
    logic [1:0]  used_q, used_d;
    logic        idelay_rst_q, user_rst_q, ready_q, fault_q;

    // Two-flop synchronisers for the asynchronous status inputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s      <= 1'b0;
            rdy_meta_q  <= 1'b0;
            rdy_s       <= 1'b0;
        end else begin
            lock_meta_q <= clk_lock;
            lock_s      <= lock_meta_q;
            rdy_meta_q  <= idelay_rdy;
            rdy_s       <= rdy_meta_q;
        end
    end

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        used_d  = used_q;
        cnt_d   = '0;

        if (!lock_s && state_q != StWaitLock && state_q != StFault) begin
            state_d = StWaitLock;
        end else if (soft_rst && state_q == StRun) begin
            state_d = StDlyRst;
            used_d  = '0;
        end else if (soft_rst) begin
            state_d = StWaitLock;
            retry_d = '0;
            used_d  = '0;
        end else begin
            case (state_q)
                StWaitLock: begin
                    if (lock_s) state_d = StLockStable;
                end
                StLockStable: begin
                    if (cnt_q == LockLast) state_d = StDlyRst;
                end
                StDlyRst: begin
                    if (cnt_q == HoldLast) state_d = StWaitRdy;
                end
                StWaitRdy: begin
                    // Ready wins over a timeout landing in the same cycle.
                    if (rdy_s) begin
                        state_d = StRun;
                        used_d  = '0;
                    end else if (cnt_q == TimeoutLast) begin
                        if (used_q < MaxRetries) begin
                            state_d = StDlyRst;
                            retry_d = sat_inc(retry_q);
                            used_d  = used_q + 2'd1;
                        end else begin
                            state_d = StFault;
                        end
                    end
                end
                StRun: begin
                    // RUN is only entered with rdy_s high, so a low rdy_s here is a fall.
                    if (!rdy_s) begin
                        state_d = StDlyRst;
                        retry_d = sat_inc(retry_q);
                    end
                end
                StFault: ;
                default: state_d = StWaitLock;
            endcase
        end

        if (state_d == state_q &&
            (state_q == StLockStable || state_q == StDlyRst || state_q == StWaitRdy)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= StWaitLock;
            cnt_q        <= '0;
            retry_q      <= '0;
            used_q       <= '0;
            idelay_rst_q <= 1'b1;
            user_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            used_q       <= used_d;
            // Outputs decode the next state so they switch on the same edge as state.
            idelay_rst_q <= (state_d == StWaitLock) || (state_d == StLockStable) ||
                            (state_d == StDlyRst);
            user_rst_q   <= (state_d != StRun);
            ready_q      <= (state_d == StRun);
            fault_q      <= (state_d == StFault);
        end
    end

    assign idelay_rst  = idelay_rst_q;
    assign user_rst    = user_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_infra_reset_sequencer.sv
module tb_infra_reset_sequencer;

    localparam int LSC = 8;
    localparam int RHC = 4;
    localparam int TO  = 16;
    localparam int MR  = 2;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       clk_lock   = 1'b1;
    logic       idelay_rdy = 1'b0;
    logic       soft_rst   = 1'b0;
    logic       idelay_rst, user_rst, ready, fault;
    logic [1:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    infra_reset_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .RST_HOLD_CYCLES   (RHC),
        .RDY_TIMEOUT       (TO),
        .MAX_RETRIES       (MR)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clk_lock   (clk_lock),
        .idelay_rdy (idelay_rdy),
        .soft_rst   (soft_rst),
        .idelay_rst (idelay_rst),
        .user_rst   (user_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .state      (state)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: phase number, cycles left in a timed phase, input delay lines.
    int m_st = 0, m_left = 0, m_retry = 0, m_used = 0;
    bit m_lock_pipe[2];
    bit m_rdy_pipe[2];
    bit m_rdy_prev = 1'b0;
    bit mv_ls, mv_rs, mv_fall;
    int mv_ns, mv_retry, mv_used;

    function automatic int dwell(input int st);
        case (st)
            1: return LSC;
            2: return RHC;
            3: return TO;
            default: return 0;
        endcase
    endfunction

    function automatic int sat3(input int v);
        return (v >= 3) ? 3 : v + 1;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_st = 0; m_left = 0; m_retry = 0; m_used = 0; m_rdy_prev = 0;
            m_lock_pipe[0] = 0; m_lock_pipe[1] = 0;
            m_rdy_pipe[0] = 0;  m_rdy_pipe[1] = 0;
        end else begin
            mv_ls = m_lock_pipe[1];
            mv_rs = m_rdy_pipe[1];
            mv_fall = m_rdy_prev && !mv_rs;
            mv_ns = m_st; mv_retry = m_retry; mv_used = m_used;
            if (!mv_ls && m_st != 0 && m_st != 5) begin
                mv_ns = 0;
            end else if (soft_rst && m_st == 4) begin
                mv_ns = 2; mv_used = 0;
            end else if (soft_rst) begin
                mv_ns = 0; mv_retry = 0; mv_used = 0;
            end else begin
                case (m_st)
                    0: if (mv_ls) mv_ns = 1;
                    1: if (m_left == 1) mv_ns = 2;
                    2: if (m_left == 1) mv_ns = 3;
                    3: begin
                        if (mv_rs) begin
                            mv_ns = 4; mv_used = 0;
                        end else if (m_left == 1) begin
                            if (m_used < MR) begin
                                mv_ns = 2; mv_retry = sat3(m_retry); mv_used = m_used + 1;
                            end else begin
                                mv_ns = 5;
                            end
                        end
                    end
                    4: if (mv_fall) begin mv_ns = 2; mv_retry = sat3(m_retry); end
                    default: ;
                endcase
            end
            if (mv_ns != m_st) m_left = dwell(mv_ns);
            else m_left = m_left - 1;
            m_st = mv_ns; m_retry = mv_retry; m_used = mv_used;
            m_rdy_prev = mv_rs;
            m_lock_pipe[1] = m_lock_pipe[0]; m_lock_pipe[0] = clk_lock;
            m_rdy_pipe[1]  = m_rdy_pipe[0];  m_rdy_pipe[0]  = idelay_rdy;
        end
    end

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            chk("model_state", int'(state), m_st);
            chk("model_idelay_rst", int'(idelay_rst), int'(m_st <= 2));
            chk("model_user_rst", int'(user_rst), int'(m_st != 4));
            chk("model_ready", int'(ready), int'(m_st == 4));
            chk("model_fault", int'(fault), int'(m_st == 5));
            chk("model_retry_count", int'(retry_count), m_retry);
            chk("idelay_rst_while_user_released", int'(idelay_rst && !user_rst), 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_state(input int code, input int budget, input string name);
        int n = 0;
        while (int'(state) != code && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(name, int'(state), code);
    endtask

    // Counts cycles spent in the current state and how many had idelay_rst high.
    task automatic count_state(input int code, output int n, output int hi);
        n = 0; hi = 0;
        while (int'(state) == code && n < 1000) begin
            n++;
            if (idelay_rst) hi++;
            @(negedge sys_clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_idelay_rst"}, int'(idelay_rst), 1);
        chk({tag, "_user_rst"}, int'(user_rst), 1);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_retry_count"}, int'(retry_count), 0);
    endtask

    int n, hi, bad_idly, rst_hold;

    initial begin
        // Reset values
        cyc(3);
        check_reset_values("reset");
        sys_rst_n = 1'b1;

        // 1. Nominal bring-up, lock high from reset
        wait_state(2, 40, "nom_reach_dly_rst");
        count_state(2, n, hi);
        chk("nom_dly_rst_cycles", n, RHC);
        chk("nom_idelay_rst_high_cycles", hi, RHC);
        chk("nom_wait_rdy_state", int'(state), 3);
        chk("nom_idelay_rst_low", int'(idelay_rst), 0);
        cyc(4);
        idelay_rdy = 1'b1;
        cyc(2);
        chk("nom_ready_not_yet", int'(ready), 0);
        cyc(1);
        chk("nom_ready_3_edges", int'(ready), 1);
        chk("nom_user_rst_low", int'(user_rst), 0);
        chk("nom_retry_zero", int'(retry_count), 0);

        // 4a. idelay_rdy lost in RUN
        cyc(3);
        idelay_rdy = 1'b0;
        cyc(2);
        chk("rdyloss_still_run", int'(state), 4);
        cyc(1);
        chk("rdyloss_state", int'(state), 2);
        chk("rdyloss_ready", int'(ready), 0);
        chk("rdyloss_user_rst", int'(user_rst), 1);
        chk("rdyloss_retry", int'(retry_count), 1);
        idelay_rdy = 1'b1;
        wait_state(4, 40, "rdyloss_back_to_run");

        // 4b. Lock lost in RUN
        cyc(2);
        clk_lock = 1'b0;
        cyc(3);
        chk("lockloss_state", int'(state), 0);
        chk("lockloss_idelay_rst", int'(idelay_rst), 1);

        // 3. Lock glitch at cycle 5 of LOCK_STABLE
        clk_lock = 1'b1;
        wait_state(1, 20, "glitch_reach_lock_stable");
        cyc(4);
        clk_lock = 1'b0;
        bad_idly = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            if (!idelay_rst) bad_idly++;
        end
        clk_lock = 1'b1;
        chk("glitch_to_wait_lock", int'(state), 0);
        n = 0;
        while (int'(state) != 1 && n < 20) begin
            @(negedge sys_clk);
            if (!idelay_rst) bad_idly++;
            n++;
        end
        chk("glitch_relock", int'(state), 1);
        count_state(1, n, hi);
        chk("glitch_full_window", n, LSC);
        chk("glitch_idelay_rst_held", bad_idly + (n - hi), 0);
        wait_state(4, 60, "glitch_run");

        // 6. Async reset during WAIT_RDY
        idelay_rdy = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        cyc(2);
        sys_rst_n = 1'b1;
        wait_state(3, 60, "areset_reach_wait_rdy");
        cyc(3);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_values("areset");
        cyc(2);
        sys_rst_n = 1'b1;

        // 2. Timeout and retry, idelay_rdy held low
        wait_state(3, 60, "to_reach_wait_rdy");
        count_state(3, n, hi);
        chk("to_wait_rdy_cycles_1", n, TO);
        chk("to_retry_state_1", int'(state), 2);
        chk("to_retry_count_1", int'(retry_count), 1);
        wait_state(3, 20, "to_reach_wait_rdy_2");
        count_state(3, n, hi);
        chk("to_wait_rdy_cycles_2", n, TO);
        chk("to_retry_state_2", int'(state), 2);
        chk("to_retry_count_2", int'(retry_count), 2);
        wait_state(3, 20, "to_reach_wait_rdy_3");
        count_state(3, n, hi);
        chk("to_wait_rdy_cycles_3", n, TO);
        chk("to_fault_state", int'(state), 5);
        chk("to_fault_flag", int'(fault), 1);
        chk("to_fault_idelay_rst", int'(idelay_rst), 0);
        chk("to_fault_user_rst", int'(user_rst), 1);

        // 5. Soft restart from FAULT
        cyc(3);
        chk("fault_sticky", int'(state), 5);
        soft_rst = 1'b1;
        cyc(1);
        soft_rst = 1'b0;
        chk("soft_state", int'(state), 0);
        chk("soft_fault", int'(fault), 0);
        chk("soft_retry", int'(retry_count), 0);
        idelay_rdy = 1'b1;
        wait_state(4, 60, "soft_bringup_run");
        chk("soft_bringup_ready", int'(ready), 1);
        chk("soft_bringup_retry", int'(retry_count), 0);

        // Randomised traffic checked against the model every cycle
        rst_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge sys_clk);
            soft_rst = ($urandom_range(0, 79) == 0);
            if (clk_lock) begin
                if ($urandom_range(0, 999) < 6) clk_lock = 1'b0;
            end else if ($urandom_range(0, 999) < 300) begin
                clk_lock = 1'b1;
            end
            if (idelay_rdy) begin
                if ($urandom_range(0, 999) < 15) idelay_rdy = 1'b0;
            end else if ($urandom_range(0, 999) < 25) begin
                idelay_rdy = 1'b1;
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) sys_rst_n = 1'b1;
            end else if ($urandom_range(0, 999) < 2) begin
                #1;
                sys_rst_n = 1'b0;
                rst_hold = 2;
            end
        end
        sys_rst_n = 1'b1;
        soft_rst = 1'b0;
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
